input_shift_register: RTL and testbench
=======================================

Name: input_shift_register

Overview:
- PIO input shift register (ISR): the inward counterpart to the pin-mapping/output path.
- Takes pin samples already mapped through the IN base/count window and shifts them into a 32-bit accumulator.
- Tracks the shift count.
- Pushes completed words to the RX FIFO, either by autopush or by an explicit PUSH, stalling the state machine when the FIFO is full.

Parameters:
- WIDTH, 32, ISR/FIFO word width. Only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cfg_shiftRight  in  1  1 = shift right (new bits enter at MSB); 0 = shift left (new bits enter at LSB).
- cfg_autopush  in  1  enables autopush.
- cfg_pushThresh  in  5  autopush/iffull threshold in bits; 0 encodes 32.
- in_valid  in  1  IN operation this cycle.
- in_data  in  32  mapped pin/source bits, right-justified.
- in_count  in  5  bit count of the IN operation; 0 encodes 32.
- push_req  in  1  explicit PUSH this cycle.
- push_block  in  1  PUSH blocks on full FIFO.
- push_iffull  in  1  PUSH only if shift_count >= threshold.
- clear  in  1  zero the ISR and shift count (MOV ISR, NULL).
- fifo_full  in  1  RX FIFO full.
- fifo_push  out  1  RX FIFO write strobe.
- fifo_data  out  32  word written to the RX FIFO.
- stall  out  1  operation not accepted; the controller must re-issue it next cycle.
- isr_value  out  32  current ISR contents.
- shift_count  out  6  bits shifted since the last clear, 0..32.

Behaviour:
- Reset: isr_value = 0, shift_count = 0; fifo_push, stall and fifo_data forced to 0 while reset is high.
- Outputs: isr_value and shift_count are registered. fifo_push, fifo_data and stall are combinational from the current state and inputs; a push is seen by the FIFO in the same cycle as the request.
- Effective widths: n = (in_count == 0) ? 32 : in_count; T = (cfg_pushThresh == 0) ? 32 : cfg_pushThresh.
- Priority, highest first: clear > push_req > in_valid. A lower-priority request in the same cycle is ignored (no stall asserted for it).
- clear: ISR and shift_count go to 0 on the next edge; no push.
- IN, shift value:
  - Bits are masked to in_data[n-1:0].
  - Right shift: S = (isr >> n) | (masked << (32-n)).
  - Left shift: S = (isr << n) | masked.
  - n = 32: S = masked, in either direction.
- IN, new count: C = min(shift_count + n, 32), i.e. saturates at 32.
- IN with autopush (cfg_autopush = 1 and C >= T):
  - fifo_full = 1: stall = 1; no state change.
  - Otherwise: fifo_push = 1 and fifo_data = S this cycle; ISR and count become 0 on the next edge.
- IN otherwise: ISR <= S, shift_count <= C.
- PUSH:
  - push_iffull = 1 and shift_count < T: no-op (no stall, no push, state kept).
  - Else if FIFO not full: fifo_push = 1, fifo_data = isr_value; ISR and count cleared.
  - Else if push_block = 1: stall = 1; state kept.
  - Else (nonblocking, full): no push; ISR and count cleared; the word is lost.
- Autopush is evaluated only on IN operations; a saturated ISR with autopush off accumulates indefinitely, shifting old bits out.
- Asynchronous reset mid-operation aborts any pending stall; no partial push.

Decomposition:
- Shared include pio_defs.vh holds:
  - WIDTH;
  - shift-direction encodings (SHIFT_LEFT = 0, SHIFT_RIGHT = 1);
  - the count-zero-means-32 helper macro, reused by the output shift register and the pin mapper.
- One natural combinational sub-module, isr_shift_unit: masking plus the directional shift merge (isr, in_data, n, dir -> S).
- The top level holds the registers, the counter and the push/stall decision.

Test Plan:
- Left shift, autopush off, T = 32: IN 8'hA5 with n = 8, then 8'h3C with n = 8 -> isr_value = 32'h0000A53C, shift_count = 16, no fifo_push.
- Right shift, autopush on, T = 8: IN 4'hB then 4'h7 -> second IN gives fifo_push = 1 with fifo_data = 32'h7B000000; next cycle isr_value = 0, shift_count = 0.
- Autopush with fifo_full = 1 at threshold: stall = 1 and state unchanged for 3 cycles; release fifo_full -> push completes in that cycle.
- PUSH iffull with shift_count = 4 and T = 8 -> no push, no stall. Blocking PUSH on full FIFO -> stall held. Nonblocking PUSH on full FIFO -> no push, ISR cleared.
- n = 0 (32-bit IN) of 32'hDEADBEEF from shift_count 5 -> isr_value = 32'hDEADBEEF, shift_count saturates at 32.
- clear together with push_req and in_valid -> ISR zeroed, no push. Assert reset mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/input_shift_register_pkg.sv
// Shared definitions for the PIO input shift register: word width,
// shift-direction encoding and the "count field of zero means 32" helper.
package input_shift_register_pkg;

    localparam int ISR_WIDTH = 32;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_e;

    // 5-bit count/threshold fields encode 32 as zero; widen to the real value.
    function automatic logic [5:0] count_eff(input logic [4:0] i_field);
        return (i_field == 5'd0) ? 6'd32 : {1'b0, i_field};
    endfunction

endpackage

// File: rtl/input_shift_register_shift_unit.sv
// Combinational merge of new IN bits into the ISR: masks the incoming data
// to n bits and shifts it in from the MSB (right) or LSB (left) side.
module input_shift_register_shift_unit
    import input_shift_register_pkg::*;
(
    input  logic [ISR_WIDTH-1:0] i_isr,
    input  logic [ISR_WIDTH-1:0] i_data,
    input  logic [5:0]           i_n,
    input  shift_dir_e           i_dir,
    output logic [ISR_WIDTH-1:0] o_shifted
);

    logic [ISR_WIDTH-1:0] w_mask;
    logic [ISR_WIDTH-1:0] w_masked;

    // n is always 1..32 here; a full-width IN simply replaces the ISR.
    always_comb begin
        w_mask    = '1;
        w_masked  = i_data;
        o_shifted = i_data;
        if (i_n != 6'd32) begin
            w_mask   = (32'h1 << i_n) - 32'd1;
            w_masked = i_data & w_mask;
            if (i_dir == SHIFT_RIGHT) begin
                o_shifted = (i_isr >> i_n) | (w_masked << (6'd32 - i_n));
            end else begin
                o_shifted = (i_isr << i_n) | w_masked;
            end
        end
    end

endmodule

// File: rtl/input_shift_register.sv
// PIO input shift register: accumulates IN bits, tracks the shift count and
// pushes completed words to the RX FIFO (autopush or explicit PUSH), stalling
// the state machine when the FIFO cannot take the word.
module input_shift_register
    import input_shift_register_pkg::*;
#(
    parameter int WIDTH = ISR_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_shiftRight,
    input  logic             cfg_autopush,
    input  logic [4:0]       cfg_pushThresh,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [4:0]       in_count,
    input  logic             push_req,
    input  logic             push_block,
    input  logic             push_iffull,
    input  logic             clear,
    input  logic             fifo_full,
    output logic             fifo_push,
    output logic [WIDTH-1:0] fifo_data,
    output logic             stall,
    output logic [WIDTH-1:0] isr_value,
    output logic [5:0]       shift_count
);

    logic [WIDTH-1:0] r_isr;
    logic [5:0]       r_cnt;

    logic [WIDTH-1:0] w_nxt_isr;
    logic [5:0]       w_nxt_cnt;
    logic [WIDTH-1:0] w_shifted;
    logic [5:0]       w_n;
    logic [5:0]       w_thresh;
    logic [6:0]       w_sum;
    logic [5:0]       w_new_cnt;

    assign w_n       = count_eff(in_count);
    assign w_thresh  = count_eff(cfg_pushThresh);
    assign w_sum     = {1'b0, r_cnt} + {1'b0, w_n};
    assign w_new_cnt = (w_sum > 7'd32) ? 6'd32 : w_sum[5:0];

    input_shift_register_shift_unit u_shift (
        .i_isr     (r_isr),
        .i_data    (in_data),
        .i_n       (w_n),
        .i_dir     (shift_dir_e'(cfg_shiftRight)),
        .o_shifted (w_shifted)
    );

    // Request arbitration (clear > push > in) and push/stall decision.
    always_comb begin
        fifo_push = 1'b0;
        fifo_data = '0;
        stall     = 1'b0;
        w_nxt_isr = r_isr;
        w_nxt_cnt = r_cnt;
        if (!reset) begin
            if (clear) begin
                w_nxt_isr = '0;
                w_nxt_cnt = '0;
            end else if (push_req) begin
                if (push_iffull && (r_cnt < w_thresh)) begin
                    // Threshold not reached: PUSH IFFULL is a no-op.
                end else if (!fifo_full) begin
                    fifo_push = 1'b1;
                    fifo_data = r_isr;
                    w_nxt_isr = '0;
                    w_nxt_cnt = '0;
                end else if (push_block) begin
                    stall = 1'b1;
                end else begin
                    // Nonblocking push to a full FIFO drops the word.
                    w_nxt_isr = '0;
                    w_nxt_cnt = '0;
                end
            end else if (in_valid) begin
                if (cfg_autopush && (w_new_cnt >= w_thresh)) begin
                    if (fifo_full) begin
                        stall = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                        fifo_data = w_shifted;
                        w_nxt_isr = '0;
                        w_nxt_cnt = '0;
                    end
                end else begin
                    w_nxt_isr = w_shifted;
                    w_nxt_cnt = w_new_cnt;
                end
            end
        end
    end

    // ISR and shift counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_isr <= '0;
            r_cnt <= '0;
        end else begin
            r_isr <= w_nxt_isr;
            r_cnt <= w_nxt_cnt;
        end
    end

    assign isr_value   = r_isr;
    assign shift_count = r_cnt;

endmodule

// File: tb/tb_input_shift_register.sv
// Scoreboard bench for input_shift_register: stimulus queues expected FIFO
// words, a monitor pops and compares whenever the DUT strobes fifo_push.
module tb_input_shift_register;

    logic        clk;
    logic        reset;
    logic        cfg_shiftRight;
    logic        cfg_autopush;
    logic [4:0]  cfg_pushThresh;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_count;
    logic        push_req;
    logic        push_block;
    logic        push_iffull;
    logic        clear;
    logic        fifo_full;
    logic        fifo_push;
    logic [31:0] fifo_data;
    logic        stall;
    logic [31:0] isr_value;
    logic [5:0]  shift_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    input_shift_register dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_shiftRight (cfg_shiftRight),
        .cfg_autopush   (cfg_autopush),
        .cfg_pushThresh (cfg_pushThresh),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_count       (in_count),
        .push_req       (push_req),
        .push_block     (push_block),
        .push_iffull    (push_iffull),
        .clear          (clear),
        .fifo_full      (fifo_full),
        .fifo_push      (fifo_push),
        .fifo_data      (fifo_data),
        .stall          (stall),
        .isr_value      (isr_value),
        .shift_count    (shift_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && fifo_push) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_push: got %h expected no push", fifo_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (fifo_data !== e) begin
                    n_fail++;
                    $display("FAIL push_data: got %h expected %h", fifo_data, e);
                end
            end
        end
    end

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_data     = '0;
        in_count    = '0;
        push_req    = 1'b0;
        push_block  = 1'b0;
        push_iffull = 1'b0;
        clear       = 1'b0;
        fifo_full   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One IN op, held for a single cycle; checks stall at mid-cycle.
    task automatic do_in(input logic [31:0] d, input logic [4:0] c, input logic exp_stall);
        in_valid = 1'b1;
        in_data  = d;
        in_count = c;
        @(negedge clk);
        chk("in_stall", {31'b0, stall}, {31'b0, exp_stall});
        next_cycle();
        in_valid = 1'b0;
    endtask

    task automatic chk_state(input string name, input logic [31:0] isr, input logic [5:0] cnt);
        chk({name, "_isr"}, isr_value, isr);
        chk({name, "_cnt"}, {26'b0, shift_count}, {26'b0, cnt});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        cfg_shiftRight = 1'b0;
        cfg_autopush   = 1'b0;
        cfg_pushThresh = 5'd0;
        idle_inputs();
        @(negedge clk);
        chk_state("reset", 32'h0, 6'd0);
        chk("reset_push", {31'b0, fifo_push}, 32'h0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Left shift, autopush off, T = 32.
        do_in(32'h0000_00A5, 5'd8, 1'b0);
        do_in(32'h0000_003C, 5'd8, 1'b0);
        chk_state("left_acc", 32'h0000_A53C, 6'd16);

        // Right shift, autopush on, T = 8.
        do_clear();
        cfg_shiftRight = 1'b1;
        cfg_autopush   = 1'b1;
        cfg_pushThresh = 5'd8;
        do_in(32'hFFFF_FFFB, 5'd4, 1'b0);
        chk_state("right_first", 32'hB000_0000, 6'd4);
        exp_q.push_back(32'h7B00_0000);
        do_in(32'h0000_0007, 5'd4, 1'b0);
        chk_state("right_autopush", 32'h0, 6'd0);

        // Autopush blocked by a full FIFO for three cycles, then released.
        cfg_shiftRight = 1'b0;
        do_in(32'h0000_0005, 5'd4, 1'b0);
        in_valid  = 1'b1;
        in_data   = 32'h0000_000A;
        in_count  = 5'd4;
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_stall", {31'b0, stall}, 32'h1);
            next_cycle();
            chk_state("full_hold", 32'h0000_0005, 6'd4);
        end
        fifo_full = 1'b0;
        exp_q.push_back(32'h0000_005A);
        @(negedge clk);
        chk("release_stall", {31'b0, stall}, 32'h0);
        next_cycle();
        in_valid = 1'b0;
        chk_state("release", 32'h0, 6'd0);

        // PUSH variants with autopush off, T = 8.
        cfg_autopush = 1'b0;
        do_in(32'h0000_0003, 5'd4, 1'b0);
        push_req    = 1'b1;
        push_iffull = 1'b1;
        @(negedge clk);
        chk("iffull_stall", {31'b0, stall}, 32'h0);
        next_cycle();
        chk_state("iffull_noop", 32'h0000_0003, 6'd4);
        push_iffull = 1'b0;
        push_block  = 1'b1;
        fifo_full   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("block_stall", {31'b0, stall}, 32'h1);
            next_cycle();
            chk_state("block_hold", 32'h0000_0003, 6'd4);
        end
        push_block = 1'b0;
        @(negedge clk);
        chk("nonblock_stall", {31'b0, stall}, 32'h0);
        next_cycle();
        chk_state("nonblock_drop", 32'h0, 6'd0);
        push_req  = 1'b0;
        fifo_full = 1'b0;
        do_in(32'h0000_0009, 5'd4, 1'b0);
        exp_q.push_back(32'h0000_0009);
        push_req = 1'b1;
        next_cycle();
        push_req = 1'b0;
        chk_state("push_ok", 32'h0, 6'd0);

        // Full-width IN (count field 0) saturates the count at 32.
        cfg_pushThresh = 5'd0;
        do_in(32'hFFFF_FFFF, 5'd5, 1'b0);
        chk_state("pre_wide", 32'h0000_001F, 6'd5);
        do_in(32'hDEAD_BEEF, 5'd0, 1'b0);
        chk_state("wide_in", 32'hDEAD_BEEF, 6'd32);
        do_in(32'h0000_0001, 5'd4, 1'b0);
        chk_state("saturated", 32'hEADB_EEF1, 6'd32);

        // clear wins over push_req and in_valid.
        clear    = 1'b1;
        push_req = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        in_count = 5'd8;
        @(negedge clk);
        chk("clear_stall", {31'b0, stall}, 32'h0);
        next_cycle();
        idle_inputs();
        chk_state("clear_prio", 32'h0, 6'd0);

        // Reset in the middle of an autopush stall.
        cfg_autopush   = 1'b1;
        cfg_pushThresh = 5'd8;
        do_in(32'h0000_0005, 5'd4, 1'b0);
        in_valid  = 1'b1;
        in_data   = 32'h0000_0006;
        in_count  = 5'd4;
        fifo_full = 1'b1;
        @(negedge clk);
        chk("pre_reset_stall", {31'b0, stall}, 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_push", {31'b0, fifo_push}, 32'h0);
        chk("rst_data", fifo_data, 32'h0);
        chk_state("rst_mid", 32'h0, 6'd0);
        next_cycle();
        idle_inputs();
        reset = 1'b0;
        next_cycle();

        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
